sw_debounce: RTL and testbench

- Input-conditioning stage directly upstream of the GPIO LED/switch block.
- Synchronises and debounces the 16 board switches and the active-low NMI pushbutton.
- Generates the periodic `tick` strobe that the GPIO block uses to time its NMI lockout.
- Exposes a small Wishbone slave for reading the debounced switches and reprogramming the tick period.

---
 rtl/sw_debounce.sv | 137 +++++++++++++
 tb/tb_sw_debounce.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
`default_nettype none
// sw_debounce -- 2-flop sync + tick-paced debounce of 16 switches and active-low pushbutton, Wishbone divider/switch regs. Rev 1.0
// Optional SW_DEBOUNCE_IRQ_EN: adds sticky irq_o, set on switch change, cleared by a write to address 0.
module sw_debounce #(
  parameter int TICK_DIV = 50000,
  parameter int DB_TICKS = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  input  logic [15:0] sw_raw_i,
  input  logic        pb_raw_i,
  output logic [15:0] sw_o,
  output logic        pb_o,
  output logic        tick_o,
`ifdef SW_DEBOUNCE_IRQ_EN
  output logic        irq_o,
`endif
  output logic        change_o
);

  localparam logic [15:0] DIV_RST = 16'(TICK_DIV - 1);
  localparam logic [2:0]  DB_LAST = 3'(DB_TICKS - 1);
  // Bit 16 carries the pushbutton, which idles high.
  localparam logic [16:0] IN_RST  = 17'h1_0000;

  logic [16:0] meta;
  logic [16:0] sync;
  logic [16:0] db_out;
  logic [15:0] div_reg;
  logic [15:0] presc;
  logic [15:0] div_new;
  logic [15:0] sw_prev;
  logic        tick;
  logic        change;
  logic        ack;
  logic        wr_div;

  assign ack     = wb_cyc_i & wb_stb_i;
  assign wr_div  = ack & wb_we_i & wb_adr_i;
  assign div_new = {wb_sel_i[1] ? wb_dat_i[15:8] : div_reg[15:8],
                    wb_sel_i[0] ? wb_dat_i[7:0]  : div_reg[7:0]};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      meta <= IN_RST;
      sync <= IN_RST;
    end else begin
      meta <= {pb_raw_i, sw_raw_i};
      sync <= meta;
    end
  end

  // A divider write restarts the period from the new value and suppresses the tick on that edge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      div_reg <= DIV_RST;
      presc   <= DIV_RST;
      tick    <= 1'b0;
    end else if (wr_div) begin
      div_reg <= div_new;
      presc   <= div_new;
      tick    <= 1'b0;
    end else if (presc == 16'd0) begin
      presc <= div_reg;
      tick  <= 1'b1;
    end else begin
      presc <= presc - 16'd1;
      tick  <= 1'b0;
    end
  end

  generate
    for (genvar i = 0; i < 17; i++) begin : g_db
      logic [2:0] cnt;
      logic       out_q;
      always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
          cnt   <= 3'd0;
          out_q <= IN_RST[i];
        end else if (sync[i] == out_q) begin
          cnt <= 3'd0;
        end else if (tick) begin
          if (cnt == DB_LAST) begin
            out_q <= sync[i];
            cnt   <= 3'd0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
      end
      assign db_out[i] = out_q;
    end
  endgenerate

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sw_prev <= 16'h0000;
      change  <= 1'b0;
    end else begin
      sw_prev <= db_out[15:0];
      change  <= |(db_out[15:0] ^ sw_prev);
    end
  end

`ifdef SW_DEBOUNCE_IRQ_EN
  logic irq;
  logic wr_sw;
  assign wr_sw = ack & wb_we_i & ~wb_adr_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)
      irq <= 1'b0;
    else if (change)
      irq <= 1'b1;
    else if (wr_sw)
      irq <= 1'b0;
  end
  assign irq_o = irq;
`endif

  assign wb_ack_o = ack;
  assign wb_dat_o = wb_adr_i ? div_reg : db_out[15:0];
  assign sw_o     = db_out[15:0];
  assign pb_o     = db_out[16];
  assign tick_o   = tick;
  assign change_o = change;

endmodule
`default_nettype wire

// File: tb/tb_sw_debounce.sv
`default_nettype none
// tb_sw_debounce -- scenario tasks; expected debounced switch words queue up on stimulus and are popped on change_o.
module tb_sw_debounce;
  localparam int TICK_DIV = 4;
  localparam int DB_TICKS = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        adr = 1'b0;
  logic [15:0] dat_i = 16'h0000;
  logic [15:0] dat_o;
  logic [1:0]  sel = 2'b00;
  logic        we = 1'b0;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        ack;
  logic [15:0] sw_raw = 16'h0000;
  logic        pb_raw = 1'b1;
  logic [15:0] sw_o;
  logic        pb_o;
  logic        tick_o;
  logic        change_o;
`ifdef SW_DEBOUNCE_IRQ_EN
  logic        irq_o;
`endif

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_sw;
  logic [15:0] rd;
  logic        rd_ack;

  sw_debounce #(.TICK_DIV(TICK_DIV), .DB_TICKS(DB_TICKS)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
    .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_ack_o(ack),
    .sw_raw_i(sw_raw), .pb_raw_i(pb_raw), .sw_o(sw_o), .pb_o(pb_o), .tick_o(tick_o),
`ifdef SW_DEBOUNCE_IRQ_EN
    .irq_o(irq_o),
`endif
    .change_o(change_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; the write lands on the next posedge and the task returns at the negedge after it.
  task automatic wb_write(input logic a, input logic [15:0] d, input logic [1:0] s);
    adr = a; dat_i = d; sel = s; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    we = 1'b0; cyc = 1'b0; stb = 1'b0; sel = 2'b00;
  endtask

  task automatic wb_read(input logic a, output logic [15:0] d, output logic k);
    adr = a; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    #1;
    d = dat_o; k = ack;
    cyc = 1'b0; stb = 1'b0;
  endtask

  // Called at the negedge where raw inputs changed; returns at the negedge where the final tick is visible.
  task automatic wait_ticks();
    int t = 0;
    int cyc_n = 0;
    repeat (2) @(posedge clk);
    while (t < DB_TICKS && cyc_n < 100) begin
      @(negedge clk);
      cyc_n++;
      if (tick_o) t++;
    end
    if (t < DB_TICKS) begin
      checks++; errors++;
      $display("FAIL tick_timeout: ticks=%0d required=%0d", t, DB_TICKS);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; adr = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (sw_o !== 16'h0000) begin errors++; $display("FAIL rst_sw: got %h want 0000", sw_o); end
    checks++; if (pb_o !== 1'b1) begin errors++; $display("FAIL rst_pb: got %b want 1", pb_o); end
    checks++; if (tick_o !== 1'b0) begin errors++; $display("FAIL rst_tick: got %b want 0", tick_o); end
    checks++; if (change_o !== 1'b0) begin errors++; $display("FAIL rst_change: got %b want 0", change_o); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b want 0", ack); end
    checks++; if (dat_o !== 16'(TICK_DIV - 1)) begin errors++; $display("FAIL rst_div: got %h want %h", dat_o, 16'(TICK_DIV - 1)); end
    @(negedge clk);
    rst = 1'b0; adr = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      checks++;
      if (tick_o !== (i % TICK_DIV == 0)) begin
        errors++; $display("FAIL idle_tick[%0d]: got %b want %b", i, tick_o, (i % TICK_DIV == 0));
      end
    end
    checks++; if (sw_o !== 16'h0000 || pb_o !== 1'b1) begin errors++; $display("FAIL idle_out: got sw=%h pb=%b want 0000/1", sw_o, pb_o); end
  endtask

  task automatic test_switches();
    sw_raw = 16'h00A5;
    exp_q.push_back(16'h00A5);
    wait_ticks();
    checks++; if (sw_o !== 16'h0000) begin errors++; $display("FAIL sw_early: got %h want 0000", sw_o); end
    @(negedge clk);
    checks++; if (sw_o !== 16'h00A5) begin errors++; $display("FAIL sw_follow: got %h want 00a5", sw_o); end
    checks++; if (change_o !== 1'b0) begin errors++; $display("FAIL change_early: got %b want 0", change_o); end
    @(negedge clk);
    checks++; if (change_o !== 1'b1) begin errors++; $display("FAIL change_pulse: got %b want 1", change_o); end
    if (change_o === 1'b1 && exp_q.size() > 0) begin
      exp_sw = exp_q.pop_front();
      checks++; if (sw_o !== exp_sw) begin errors++; $display("FAIL sb_sw: got %h want %h", sw_o, exp_sw); end
    end
    @(negedge clk);
    checks++; if (change_o !== 1'b0) begin errors++; $display("FAIL change_once: got %b want 0", change_o); end
    wb_read(1'b0, rd, rd_ack);
    checks++; if (rd !== 16'h00A5 || rd_ack !== 1'b1) begin errors++; $display("FAIL rd_sw: got %h ack=%b want 00a5 ack=1", rd, rd_ack); end
  endtask

  task automatic test_glitch();
    int seen = 0;
    int bad = 0;
    @(negedge clk);
    sw_raw = 16'h00A4;
    repeat (5) @(negedge clk);
    sw_raw = 16'h00A5;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (change_o) seen++;
      if (sw_o !== 16'h00A5) bad++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL glitch_change: got %0d pulses want 0", seen); end
    checks++; if (bad != 0) begin errors++; $display("FAIL glitch_sw: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_div_write();
    logic want;
    wb_write(1'b1, 16'h0001, 2'b01);
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) @(negedge clk);
      want = (i >= 3) && (i % 2 == 1);
      checks++;
      if (tick_o !== want) begin errors++; $display("FAIL div_tick[%0d]: got %b want %b", i, tick_o, want); end
    end
    wb_read(1'b1, rd, rd_ack);
    checks++; if (rd !== 16'h0001) begin errors++; $display("FAIL rd_div1: got %h want 0001", rd); end
  endtask

  task automatic test_partial_write();
    @(negedge clk);
    wb_write(1'b1, 16'hFF00, 2'b10);
    wb_read(1'b1, rd, rd_ack);
    checks++; if (rd !== 16'hFF01) begin errors++; $display("FAIL rd_partial: got %h want ff01", rd); end
    @(negedge clk);
    wb_write(1'b1, 16'h0003, 2'b11);
    wb_read(1'b1, rd, rd_ack);
    checks++; if (rd !== 16'h0003) begin errors++; $display("FAIL rd_div3: got %h want 0003", rd); end
  endtask

  task automatic test_pb();
    @(negedge clk);
    pb_raw = 1'b0;
    wait_ticks();
    checks++; if (pb_o !== 1'b1) begin errors++; $display("FAIL pb_early: got %b want 1", pb_o); end
    @(negedge clk);
    checks++; if (pb_o !== 1'b0) begin errors++; $display("FAIL pb_follow: got %b want 0", pb_o); end
    @(negedge clk);
    checks++; if (change_o !== 1'b0) begin errors++; $display("FAIL pb_change: got %b want 0", change_o); end
    pb_raw = 1'b1;
    wait_ticks();
    @(negedge clk);
    checks++; if (pb_o !== 1'b1) begin errors++; $display("FAIL pb_release: got %b want 1", pb_o); end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    int n = 0;
    @(negedge clk);
    wb_write(1'b1, 16'h0002, 2'b11);
    pb_raw = 1'b0;
    repeat (2) @(posedge clk);
    while (t < 2 && n < 100) begin
      @(negedge clk);
      n++;
      if (tick_o) t++;
    end
    @(negedge clk);
    rst = 1'b1; adr = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (pb_o !== 1'b1) begin errors++; $display("FAIL mid_pb: got %b want 1", pb_o); end
    checks++; if (tick_o !== 1'b0 || change_o !== 1'b0) begin errors++; $display("FAIL mid_pulse: got tick=%b change=%b want 0/0", tick_o, change_o); end
    checks++; if (sw_o !== 16'h0000) begin errors++; $display("FAIL mid_sw: got %h want 0000", sw_o); end
    checks++; if (dat_o !== 16'(TICK_DIV - 1)) begin errors++; $display("FAIL mid_div: got %h want %h", dat_o, 16'(TICK_DIV - 1)); end
    rst = 1'b0; adr = 1'b0;
    exp_q.push_back(16'h00A5);
    wait_ticks();
    checks++; if (pb_o !== 1'b1) begin errors++; $display("FAIL mid_cleared: got pb=%b want 1", pb_o); end
    @(negedge clk);
    checks++; if (pb_o !== 1'b0) begin errors++; $display("FAIL mid_pb_follow: got %b want 0", pb_o); end
    @(negedge clk);
    checks++; if (change_o !== 1'b1) begin errors++; $display("FAIL mid_change: got %b want 1", change_o); end
    if (change_o === 1'b1 && exp_q.size() > 0) begin
      exp_sw = exp_q.pop_front();
      checks++; if (sw_o !== exp_sw) begin errors++; $display("FAIL sb_mid_sw: got %h want %h", sw_o, exp_sw); end
    end
  endtask

`ifdef SW_DEBOUNCE_IRQ_EN
  task automatic test_irq();
    @(negedge clk);
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_set: got %b want 1", irq_o); end
    wb_write(1'b0, 16'h1234, 2'b11);
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", irq_o); end
    wb_read(1'b0, rd, rd_ack);
    checks++; if (rd !== 16'h00A5) begin errors++; $display("FAIL irq_rd: got %h want 00a5", rd); end
    sw_raw = 16'h00A7;
    exp_q.push_back(16'h00A7);
    wait_ticks();
    @(negedge clk);
    @(negedge clk);
    checks++; if (change_o !== 1'b1) begin errors++; $display("FAIL irq_change: got %b want 1", change_o); end
    if (change_o === 1'b1 && exp_q.size() > 0) begin
      exp_sw = exp_q.pop_front();
      checks++; if (sw_o !== exp_sw) begin errors++; $display("FAIL sb_irq_sw: got %h want %h", sw_o, exp_sw); end
    end
    wb_write(1'b0, 16'h0000, 2'b11);
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_set_wins: got %b want 1", irq_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_switches();
    test_glitch();
    test_div_write();
    test_partial_write();
    test_pb();
    test_reset_mid();
`ifdef SW_DEBOUNCE_IRQ_EN
    test_irq();
`endif
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d entries want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
